// File: rtl/rx_pkt_ctrl.sv
// Packet-receive sequencer: arms the RX datapath, drains the byte FIFO after an access-address
// match, and forwards header+payload+CRC bytes over valid/ready. Option macro: RX_PKT_CTRL_TIMEOUT_EN.
module rx_pkt_ctrl #(
    parameter logic [7:0]  LEN_MASK = 8'h3F,
    parameter int unsigned TO_W     = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic            abort,
    input  logic [TO_W-1:0] to_cycles,
    output logic            rx_en,
    output logic            rx_start,
    input  logic            aa_found,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [7:0]      fifo_data,
    input  logic            crc_valid,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            byte_last,
    output logic [7:0]      pdu_len,
    output logic            busy,
    output logic            done,
    output logic            crc_ok,
    output logic            timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SEARCH, S_READ, S_WAIT, S_CHECK, S_END
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [7:0]  len_q, len_d;
    logic        crc_ok_q, crc_ok_d;
    logic        timeout_q, timeout_d;
    logic        rd;
    logic        out_free;
    logic        is_last;

`ifdef RX_PKT_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_inc;
    assign to_inc = to_cnt_q + 1'b1;
`else
    logic to_cycles_unused;
    assign to_cycles_unused = ^to_cycles;
`endif

    assign out_free = !valid_q || byte_ready;
    // Last byte index is 4 + payload length; the length is only known from index 1 on.
    assign is_last  = (cnt_q >= 9'd2) && (cnt_q == (9'd4 + {1'b0, len_q}));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        last_d    = last_q;
        len_d     = len_q;
        crc_ok_d  = crc_ok_q;
        timeout_d = timeout_q;
        rd        = 1'b0;
`ifdef RX_PKT_CTRL_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        if (valid_q && byte_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (go && !abort) begin
                    state_d   = S_ARM;
                    cnt_d     = '0;
                    len_d     = '0;
                    crc_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                end
            end
            S_ARM: begin
                state_d = S_SEARCH;
`ifdef RX_PKT_CTRL_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_SEARCH: begin
                if (aa_found) begin
                    state_d = S_READ;
`ifdef RX_PKT_CTRL_TIMEOUT_EN
                end else if ((to_cycles != '0) && (to_inc == to_cycles)) begin
                    timeout_d = 1'b1;
                    crc_ok_d  = 1'b0;
                    state_d   = S_END;
                end else begin
                    to_cnt_d = to_inc;
`endif
                end
            end
            S_READ: begin
                if (!fifo_empty && out_free) begin
                    rd      = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                byte_d  = fifo_data;
                valid_d = 1'b1;
                last_d  = is_last;
                cnt_d   = cnt_q + 9'd1;
                if (cnt_q == 9'd1) begin
                    len_d = fifo_data & LEN_MASK;
                end
                state_d = is_last ? S_CHECK : S_READ;
            end
            S_CHECK: begin
                if (valid_q && byte_ready) begin
                    crc_ok_d = crc_valid;
                    state_d  = S_END;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards the in-flight byte but leaves the reported status untouched.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            rd        = 1'b0;
            len_d     = len_q;
            crc_ok_d  = crc_ok_q;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            len_q     <= '0;
            crc_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            len_q     <= len_d;
            crc_ok_q  <= crc_ok_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RX_PKT_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign rx_en      = (state_q == S_ARM) || (state_q == S_SEARCH) || (state_q == S_READ) ||
                        (state_q == S_WAIT) || (state_q == S_CHECK);
    assign rx_start   = (state_q == S_ARM);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_END);
    assign fifo_rd_en = rd;
    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign byte_last  = valid_q && last_q;
    assign pdu_len    = len_q;
    assign crc_ok     = crc_ok_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Scoreboard bench for rx_pkt_ctrl: driver queues expected bytes/status, monitor checks them as the
// DUT presents them. Timeout scenario only when RX_PKT_CTRL_TIMEOUT_EN is defined.
module tb_rx_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] to_cycles = '0;
    logic        rx_en, rx_start;
    logic        aa_found = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = '0;
    logic        crc_valid = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        byte_last;
    logic [7:0]  pdu_len;
    logic        busy, done, crc_ok, timeout;

    int checks = 0;
    int fails  = 0;
    int n_acc  = 0;
    int done_cnt = 0;

    logic [8:0] exp_q[$];   // {last, data}
    logic [9:0] exp_st[$];  // {crc_ok, timeout, pdu_len}

    logic [7:0]  mem [16];
    int unsigned wr_cnt = 0;
    int unsigned rd_ptr = 0;
    logic [7:0]  pkt [16];

    rx_pkt_ctrl #(.LEN_MASK(8'h3F), .TO_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .to_cycles(to_cycles),
        .rx_en(rx_en), .rx_start(rx_start), .aa_found(aa_found), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .crc_valid(crc_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .pdu_len(pdu_len), .busy(busy), .done(done),
        .crc_ok(crc_ok), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // FIFO model: flushed by rx_start, data appears the cycle after a read strobe.
    assign fifo_empty = (rd_ptr >= wr_cnt);
    always @(posedge clk) begin
        if (rx_start) begin
            rd_ptr <= 0;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        logic pv, pr;
        logic [7:0] pb;
        logic [8:0] e;
        logic [9:0] s;
        pv = 1'b0; pr = 1'b0; pb = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    chk("hold_valid", byte_valid, 1'b1);
                    chk("hold_data", byte_out, pb);
                end
                if (fifo_rd_en) begin
                    chk("rd_when_empty", fifo_empty, 1'b0);
                    chk("rd_out_busy", byte_valid && !byte_ready, 1'b0);
                end
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", byte_out, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_data", byte_out, e[7:0]);
                        chk("byte_last", byte_last, e[8]);
                    end
                    n_acc++;
                end
                if (done) begin
                    done_cnt++;
                    if (exp_st.size() == 0) begin
                        chk("unexpected_done", done, 1'b0);
                    end else begin
                        s = exp_st.pop_front();
                        chk("crc_ok", crc_ok, s[9]);
                        chk("timeout", timeout, s[8]);
                        chk("pdu_len", pdu_len, s[7:0]);
                    end
                end
            end
            pv = byte_valid; pr = byte_ready; pb = byte_out;
        end
    end

    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (n_acc < target) chk("acc_wait_expired", n_acc, target);
    endtask

    task automatic run_pkt(input int n, input logic crc, input int stall_after, input bit extra_go);
        logic [7:0] len;
        int d0, base, k;
        len = pkt[1] & 8'h3F;
        wr_cnt = 0;
        for (int i = 0; i < n; i++) mem[i] = pkt[i];
        mem[n] = 8'hEE;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == 4 + int'(len)), pkt[i]});
        exp_st.push_back({crc, 1'b0, len});
        crc_valid = crc;
        d0 = done_cnt;
        base = n_acc;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        chk("arm_rx_start", rx_start, 1'b1);
        chk("arm_rx_en", rx_en, 1'b1);
        chk("arm_busy", busy, 1'b1);
        chk("arm_pdu_clr", pdu_len, 8'h00);
        chk("arm_crc_clr", crc_ok, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        if (extra_go) begin
            go = 1'b1;
            @(posedge clk); #1 go = 1'b0;
        end
        aa_found = 1'b1;
        wr_cnt = n + 1;
        if (stall_after > 0) begin
            wait_acc(base + stall_after);
            byte_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 byte_ready = 1'b1;
        end
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            @(negedge clk); k++;
        end
        if (done_cnt == d0) begin
            chk("done_wait_expired", done_cnt, d0 + 1);
        end else begin
            chk("end_rx_en", rx_en, 1'b0);
            @(negedge clk);
            chk("post_busy", busy, 1'b0);
            chk("single_done", done_cnt, d0 + 1);
        end
        aa_found = 1'b0;
        chk("no_overread", rd_ptr, n);
        chk("all_bytes_out", exp_q.size(), 0);
        chk("byte_count", n_acc - base, n);
    endtask

    initial begin
        int d0, rp;
`ifdef RX_PKT_CTRL_TIMEOUT_EN
        int c;
        to_cycles = '0;
`else
        to_cycles = 20'd5;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outs", {rx_en, rx_start, fifo_rd_en, byte_out, byte_valid, byte_last,
                           pdu_len, busy, done, crc_ok, timeout}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        pkt[0] = 8'h02; pkt[1] = 8'h03; pkt[2] = 8'hAA; pkt[3] = 8'hBB;
        pkt[4] = 8'hCC; pkt[5] = 8'hC1; pkt[6] = 8'hC2; pkt[7] = 8'hC3;
        run_pkt(8, 1'b1, 0, 1'b1);
        run_pkt(8, 1'b0, 0, 1'b0);

        pkt[0] = 8'h01; pkt[1] = 8'hC0; pkt[2] = 8'hD1; pkt[3] = 8'hD2; pkt[4] = 8'hD3;
        run_pkt(5, 1'b1, 0, 1'b0);

        pkt[0] = 8'h05; pkt[1] = 8'h04; pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33;
        pkt[5] = 8'h44; pkt[6] = 8'hE1; pkt[7] = 8'hE2; pkt[8] = 8'hE3;
        run_pkt(9, 1'b1, 3, 1'b0);

`ifdef RX_PKT_CTRL_TIMEOUT_EN
        to_cycles = 20'd100;
        exp_st.push_back({1'b0, 1'b1, 8'h00});
        d0 = done_cnt;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        c = 1;
        @(negedge clk);
        while (!done && c < 300) begin
            @(posedge clk); c++;
            @(negedge clk);
        end
        chk("timeout_cycle", c, 102);
        chk("timeout_rx_en", rx_en, 1'b0);
        @(negedge clk);
        chk("timeout_idle", busy, 1'b0);
        chk("timeout_held", timeout, 1'b1);
        chk("timeout_done", done_cnt, d0 + 1);
        to_cycles = '0;
        @(posedge clk); #1;
`endif

        // abort mid-payload
        pkt[0] = 8'h02; pkt[1] = 8'h03; pkt[2] = 8'hAA; pkt[3] = 8'hBB;
        pkt[4] = 8'hCC; pkt[5] = 8'hC1; pkt[6] = 8'hC2; pkt[7] = 8'hC3;
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) mem[i] = pkt[i];
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), pkt[i]});
        crc_valid = 1'b1;
        d0 = done_cnt;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (5) @(posedge clk);
        #1 aa_found = 1'b1;
        wr_cnt = 8;
        wait_acc(n_acc + 3);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 1'b0);
        chk("abort_rx_en", rx_en, 1'b0);
        chk("abort_valid", byte_valid, 1'b0);
        chk("abort_len_kept", pdu_len, 8'h03);
        exp_q.delete();
        rp = rd_ptr;
        aa_found = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_read", rd_ptr, rp);

        // go and abort together in IDLE: abort wins
        @(posedge clk); #1;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1 go = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("go_abort_busy", busy, 1'b0);
        chk("go_abort_start", rx_start, 1'b0);
        @(posedge clk); #1;

        run_pkt(8, 1'b1, 0, 1'b0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
